id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-003 SHALL have ports in this order, one per line:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  ID holds a real instruction
- i_opcode  in  7  ID instruction opcode
- i_ctrl  in  8  {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, alu_op[1:0]} from decode control
- i_rs1_data  in  XLEN  register-file read 1
- i_rs2_data  in  XLEN  register-file read 2
- i_imm  in  XLEN  sign-extended immediate
- i_pc  in  XLEN  instruction PC
- i_rs1  in  5  source index 1
- i_rs2  in  5  source index 2
- i_rd  in  5  destination index
- i_funct  in  4  {funct7[5], funct3}
- i_flush  in  1  taken-branch squash of the ID instruction
- i_hold  in  1  global pipeline freeze
- o_valid  out  1  EX holds a real instruction
- o_ctrl  out  8  registered i_ctrl
- o_rs1_data  out  XLEN  registered
- o_rs2_data  out  XLEN  registered
- o_imm  out  XLEN  registered
- o_pc  out  XLEN  registered
- o_rs1  out  5  registered
- o_rs2  out  5  registered
- o_rd  out  5  registered
- o_funct  out  4  registered
- o_stall  out  1  combinational load-use stall to PC and IF/ID
- o_stall_cnt  out  CNT_W  bubbles inserted by load-use stall
- o_flush_cnt  out  CNT_W  bubbles inserted by flush

Function
REQ-004 SHALL treat rs1 as used for opcodes 0110011, 0000011, 0100011, 1100011; rs2 as used for 0110011, 0100011, 1100011; other opcodes use neither.
REQ-005 SHALL assert hazard when i_valid & o_valid & o_ctrl[5] (mem_read) & o_rd!=0 & ((rs1 used & o_rd==i_rs1) | (rs2 used & o_rd==i_rs2)).
REQ-006 SHALL drive o_stall = hazard & ~i_flush & ~i_hold, same cycle, no register.
REQ-007 SHALL apply per-edge priority: i_rst > i_flush > i_hold > o_stall > load.
REQ-008 Bubble (flush or stall): o_valid=0, o_ctrl=0; data, index, pc, funct fields SHALL also clear to 0.
REQ-009 Hold: all registers and counters SHALL keep their value.
REQ-010 Load: all outputs SHALL take inputs, o_valid=i_valid; when i_valid=0, o_ctrl SHALL be 0.
REQ-011 Latency SHALL be exactly one cycle from ID inputs to EX outputs.
REQ-012 o_stall_cnt SHALL increment by 1 on each edge a stall bubble is inserted; o_flush_cnt on each edge a flush bubble is inserted; both saturate at all-ones.
REQ-013 Flush coincident with hazard SHALL insert one flush bubble, count only flush, o_stall=0.
REQ-014 Stall SHALL last exactly one cycle per load-use pair, since the bubble clears o_ctrl[5].
REQ-015 Hazard coincident with hold SHALL re-evaluate after hold drops, with no lost or duplicated stall.

Reset
REQ-016 On i_rst at a rising edge, every registered output and both counters SHALL be 0; o_stall SHALL be 0 the cycle after.
REQ-017 Reset asserted mid-stall or mid-hold SHALL discard EX contents without counting.

Verification
REQ-018 Load x5 (o_rd=5, mem_read) in EX, ID R-type i_rs2=5 -> o_stall=1 one cycle, next o_valid=0, o_ctrl=0, o_stall_cnt=1.
REQ-019 Load o_rd=0, ID i_rs1=0 -> o_stall=0, instruction loads next edge.
REQ-020 Hazard plus i_flush=1 -> o_stall=0, bubble, o_flush_cnt=1, o_stall_cnt=0.
REQ-021 i_hold=1 three cycles with o_pc=0x10 -> o_pc stays 0x10, counters unchanged, o_stall=0.
REQ-022 o_flush_cnt preset to 0xFFFF via 65535 flushes, one more flush -> stays 0xFFFF.
REQ-023 i_rst during a stall cycle -> next edge all outputs 0, o_stall_cnt=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
//
// Captures the decoded instruction from ID and presents it to EX one cycle later.
// A load in EX whose destination is read by the instruction in ID forces a one-cycle
// bubble (o_stall tells PC and IF/ID to hold).
//
// Per-edge priority: i_rst > i_flush > i_hold > o_stall > load.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, i_opcode,
//   i_ctrl, i_rs1_data,
//   i_rs2_data, i_imm,
//   i_pc, i_rs1, i_rs2,
//   i_rd, i_funct       instruction fields from ID
//   i_flush             squash the ID instruction (taken branch)
//   i_hold              freeze the whole stage
//   o_valid .. o_funct  registered EX-side copies of the ID fields
//   o_stall             combinational load-use stall request
//   o_stall_cnt         saturating count of stall bubbles
//   o_flush_cnt         saturating count of flush bubbles
//
// i_ctrl layout: {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, alu_op[1:0]}
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [6:0]       i_opcode,
    input  logic [7:0]       i_ctrl,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [4:0]       i_rd,
    input  logic [3:0]       i_funct,
    input  logic             i_flush,
    input  logic             i_hold,
    output logic             o_valid,
    output logic [7:0]       o_ctrl,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic [XLEN-1:0]  o_imm,
    output logic [XLEN-1:0]  o_pc,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic [3:0]       o_funct,
    output logic             o_stall,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    localparam int unsigned CtrlMemRead = 5;

    logic rs1_used;
    logic rs2_used;
    logic hazard;

    // Only opcodes that actually read a source register can create a load-use hazard.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (i_opcode)
            OpRType, OpStore, OpBranch: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OpLoad: rs1_used = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        hazard = i_valid && o_valid && o_ctrl[CtrlMemRead] && (o_rd != 5'd0) &&
                 ((rs1_used && (o_rd == i_rs1)) || (rs2_used && (o_rd == i_rs2)));
        // Flush and hold both override the stall, so it is never requested under them.
        o_stall = hazard && !i_flush && !i_hold;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_ctrl      <= '0;
            o_rs1_data  <= '0;
            o_rs2_data  <= '0;
            o_imm       <= '0;
            o_pc        <= '0;
            o_rs1       <= '0;
            o_rs2       <= '0;
            o_rd        <= '0;
            o_funct     <= '0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else if (i_flush || (!i_hold && o_stall)) begin
            // Bubble: everything cleared, so the next cycle cannot see a stale load.
            o_valid    <= 1'b0;
            o_ctrl     <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_imm      <= '0;
            o_pc       <= '0;
            o_rs1      <= '0;
            o_rs2      <= '0;
            o_rd       <= '0;
            o_funct    <= '0;
            if (i_flush) begin
                if (o_flush_cnt != CntMax) begin
                    o_flush_cnt <= o_flush_cnt + CntOne;
                end
            end else if (o_stall_cnt != CntMax) begin
                o_stall_cnt <= o_stall_cnt + CntOne;
            end
        end else if (!i_hold) begin
            o_valid    <= i_valid;
            o_ctrl     <= i_valid ? i_ctrl : 8'd0;
            o_rs1_data <= i_rs1_data;
            o_rs2_data <= i_rs2_data;
            o_imm      <= i_imm;
            o_pc       <= i_pc;
            o_rs1      <= i_rs1;
            o_rs2      <= i_rs2;
            o_rd       <= i_rd;
            o_funct    <= i_funct;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [7:0] CtrlLoad  = 8'hE8;  // reg_write, alu_src, mem_read, mem_to_reg
    localparam logic [7:0] CtrlRType = 8'h82;  // reg_write, alu_op=10

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [6:0]       opcode;
    logic [7:0]       ctrl;
    logic [XLEN-1:0]  rs1_data, rs2_data, imm, pc;
    logic [4:0]       rs1, rs2, rd;
    logic [3:0]       funct;
    logic             flush, hold;
    logic             o_valid;
    logic [7:0]       o_ctrl;
    logic [XLEN-1:0]  o_rs1_data, o_rs2_data, o_imm, o_pc;
    logic [4:0]       o_rs1, o_rs2, o_rd;
    logic [3:0]       o_funct;
    logic             o_stall;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_opcode(opcode), .i_ctrl(ctrl),
        .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm), .i_pc(pc),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_funct(funct),
        .i_flush(flush), .i_hold(hold),
        .o_valid(o_valid), .o_ctrl(o_ctrl), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct(o_funct),
        .o_stall(o_stall), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        valid = 0; opcode = 7'b0010011; ctrl = 0; rs1_data = 0; rs2_data = 0;
        imm = 0; pc = 0; rs1 = 0; rs2 = 0; rd = 0; funct = 0;
    endtask

    task automatic drive_load(input logic [4:0] d, input logic [XLEN-1:0] p);
        valid = 1; opcode = 7'b0000011; ctrl = CtrlLoad; rs1 = 5'd2; rs2 = 5'd0;
        rd = d; pc = p; imm = 32'd4; rs1_data = 32'h1000; rs2_data = 0; funct = 4'b0010;
    endtask

    task automatic drive_rtype(input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic [XLEN-1:0] p);
        valid = 1; opcode = 7'b0110011; ctrl = CtrlRType; rs1 = s1; rs2 = s2; rd = d;
        pc = p; imm = 0; rs1_data = 32'hAA; rs2_data = 32'hBB; funct = 4'b1000;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, 64'(o_valid), 64'd0);
        check_eq({tag, "_ctrl"},  64'(o_ctrl),  64'd0);
        check_eq({tag, "_pc"},    64'(o_pc),    64'd0);
        check_eq({tag, "_rd"},    64'(o_rd),    64'd0);
        check_eq({tag, "_rs2d"},  64'(o_rs2_data), 64'd0);
        check_eq({tag, "_funct"}, 64'(o_funct), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1; drive_idle(); flush = 0; hold = 0;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1; flush = 0; hold = 0; drive_idle();
        step();
        check_cleared("reset");
        check_eq("reset_stall_cnt", 64'(o_stall_cnt), 64'd0);
        check_eq("reset_flush_cnt", 64'(o_flush_cnt), 64'd0);
        check_eq("reset_stall",     64'(o_stall),     64'd0);
        rst = 0;

        // Load-use via rs2: one stall cycle, bubble, then the R-type loads.
        drive_load(5'd5, 32'h100);
        step();
        check_eq("ld_valid", 64'(o_valid), 64'd1);
        check_eq("ld_ctrl",  64'(o_ctrl),  64'hE8);
        check_eq("ld_rd",    64'(o_rd),    64'd5);
        check_eq("ld_pc",    64'(o_pc),    64'h100);
        drive_rtype(5'd3, 5'd5, 5'd7, 32'h104);
        settle();
        check_eq("lu_stall", 64'(o_stall), 64'd1);
        step();
        check_cleared("lu_bubble");
        check_eq("lu_stall_cnt", 64'(o_stall_cnt), 64'd1);
        check_eq("lu_stall_after", 64'(o_stall), 64'd0);
        step();
        check_eq("lu_r_valid", 64'(o_valid), 64'd1);
        check_eq("lu_r_ctrl",  64'(o_ctrl),  64'h82);
        check_eq("lu_r_rs2",   64'(o_rs2),   64'd5);
        check_eq("lu_r_rd",    64'(o_rd),    64'd7);
        check_eq("lu_r_rs2d",  64'(o_rs2_data), 64'hBB);
        check_eq("lu_r_funct", 64'(o_funct), 64'd8);
        check_eq("lu_r_cnt",   64'(o_stall_cnt), 64'd1);

        // Load to x0 never stalls.
        drive_load(5'd0, 32'h1FC);
        step();
        drive_rtype(5'd0, 5'd0, 5'd9, 32'h200);
        settle();
        check_eq("x0_stall", 64'(o_stall), 64'd0);
        step();
        check_eq("x0_valid", 64'(o_valid), 64'd1);
        check_eq("x0_rd",    64'(o_rd),    64'd9);
        check_eq("x0_pc",    64'(o_pc),    64'h200);

        // Opcode that reads no register (LUI) does not stall on a matching index.
        drive_load(5'd6, 32'h300);
        step();
        drive_rtype(5'd6, 5'd6, 5'd1, 32'h304);
        opcode = 7'b0110111;
        settle();
        check_eq("lui_stall", 64'(o_stall), 64'd0);
        // Load consumer uses rs1 only: matching rs2 alone is no hazard, rs1 is.
        opcode = 7'b0000011; rs1 = 5'd1; rs2 = 5'd6;
        settle();
        check_eq("ld_rs2_nostall", 64'(o_stall), 64'd0);
        rs1 = 5'd6;
        settle();
        check_eq("ld_rs1_stall", 64'(o_stall), 64'd1);
        valid = 0;
        settle();
        check_eq("invalid_nostall", 64'(o_stall), 64'd0);

        // Hazard coincident with flush: flush bubble only.
        do_reset();
        drive_load(5'd5, 32'h400);
        step();
        drive_rtype(5'd5, 5'd1, 5'd2, 32'h404);
        flush = 1;
        settle();
        check_eq("fl_stall", 64'(o_stall), 64'd0);
        step();
        flush = 0;
        check_cleared("fl_bubble");
        check_eq("fl_flush_cnt", 64'(o_flush_cnt), 64'd1);
        check_eq("fl_stall_cnt", 64'(o_stall_cnt), 64'd0);

        // Hold freezes everything for three cycles.
        drive_rtype(5'd1, 5'd2, 5'd3, 32'h10);
        step();
        check_eq("hd_pc_pre", 64'(o_pc), 64'h10);
        hold = 1;
        drive_rtype(5'd4, 5'd4, 5'd8, 32'h14);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hd_pc", 64'(o_pc), 64'h10);
            check_eq("hd_rd", 64'(o_rd), 64'd3);
            check_eq("hd_stall", 64'(o_stall), 64'd0);
            check_eq("hd_cnts", 64'({o_stall_cnt, o_flush_cnt}), 64'h0000_0001);
        end
        hold = 0;

        // Hazard under hold: deferred, then exactly one stall.
        drive_load(5'd5, 32'h500);
        step();
        drive_rtype(5'd5, 5'd0, 5'd2, 32'h504);
        hold = 1;
        settle();
        check_eq("hh_stall_held", 64'(o_stall), 64'd0);
        step();
        check_eq("hh_valid_held", 64'(o_valid), 64'd1);
        check_eq("hh_cnt_held", 64'(o_stall_cnt), 64'd0);
        hold = 0;
        settle();
        check_eq("hh_stall_rel", 64'(o_stall), 64'd1);
        step();
        check_eq("hh_cnt", 64'(o_stall_cnt), 64'd1);
        check_eq("hh_stall_once", 64'(o_stall), 64'd0);
        step();
        check_eq("hh_r_pc", 64'(o_pc), 64'h504);
        check_eq("hh_cnt_final", 64'(o_stall_cnt), 64'd1);

        // Reset during a stall cycle discards EX contents without counting.
        drive_load(5'd7, 32'h600);
        step();
        drive_rtype(5'd0, 5'd7, 5'd2, 32'h604);
        settle();
        check_eq("rs_stall_pre", 64'(o_stall), 64'd1);
        rst = 1;
        step();
        check_cleared("rs");
        check_eq("rs_stall_cnt", 64'(o_stall_cnt), 64'd0);
        check_eq("rs_flush_cnt", 64'(o_flush_cnt), 64'd0);
        rst = 0;
        settle();
        check_eq("rs_stall_after", 64'(o_stall), 64'd0);

        // Flush counter saturation.
        flush = 1;
        repeat (65535) step();
        check_eq("sat_pre", 64'(o_flush_cnt), 64'hFFFF);
        step();
        check_eq("sat_hold", 64'(o_flush_cnt), 64'hFFFF);
        check_eq("sat_stall_cnt", 64'(o_stall_cnt), 64'd0);
        flush = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
